// File: rtl/key_event_ctrl.sv
// Push-button front end: synchronizes and debounces four active-low keys, keeps
// per-key toggle state, and queues press/release events behind a valid/ready FWFT queue.
module key_event_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_n,
  output logic [3:0] key_pressed,
  output logic [3:0] key_toggle,
  output logic       evt_valid,
  output logic [2:0] evt_code,
  input  logic       evt_ready,
  output logic       evt_overflow,
  input  logic       evt_clr
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_ZERO  = PTR_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [OCC_W-1:0] OCC_ZERO  = OCC_W'(0);
  localparam logic [OCC_W-1:0] OCC_ONE   = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);

  logic [3:0]       sync1_r;
  logic [3:0]       sync2_r;
  logic [3:0]       stable_r;
  logic [CNT_W-1:0] cnt_r [4];
  logic [3:0]       toggle_r;
  logic [3:0]       pend_r;
  logic [3:0]       pdir_r;
  logic             ovf_r;
  logic [2:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [OCC_W-1:0] occ_r;

  logic [3:0]       stable_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s [4];
  logic [3:0]       trans_s;
  logic [3:0]       press_s;
  logic             push_s;
  logic             pop_s;
  logic [1:0]       push_idx_s;
  logic [2:0]       push_code_s;
  logic [3:0]       clr_s;
  logic [3:0]       pend_nxt_s;
  logic [3:0]       pdir_nxt_s;
  logic [3:0]       drop_s;
  logic             ovf_nxt_s;
  logic [OCC_W-1:0] occ_nxt_s;

  // Per-key debounce: count consecutive cycles the synchronized level differs from stable.
  always_comb begin
    stable_nxt_s = stable_r;
    cnt_nxt_s    = cnt_r;
    for (int i = 0; i < 4; i++) begin
      if (sync2_r[i] == stable_r[i]) begin
        cnt_nxt_s[i] = CNT_ZERO;
      end else if (cnt_r[i] == CNT_LAST) begin
        stable_nxt_s[i] = sync2_r[i];
        cnt_nxt_s[i]    = CNT_ZERO;
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
      end
    end
  end

  assign trans_s = stable_nxt_s ^ stable_r;
  assign press_s = trans_s & stable_r;

  // Arbiter: lowest-index pending key is pushed whenever the queue has room.
  always_comb begin
    casez (pend_r)
      4'b???1: push_idx_s = 2'd0;
      4'b??10: push_idx_s = 2'd1;
      4'b?100: push_idx_s = 2'd2;
      4'b1000: push_idx_s = 2'd3;
      default: push_idx_s = 2'd0;
    endcase
    push_s      = (|pend_r) && (occ_r < OCC_FULL);
    push_code_s = {push_idx_s, pdir_r[push_idx_s]};
    if (push_s) begin
      clr_s = 4'b0001 << push_idx_s;
    end else begin
      clr_s = 4'b0000;
    end
  end

  // Pending flags: an unserviced older event is kept and the newer one is dropped.
  always_comb begin
    pend_nxt_s = pend_r;
    pdir_nxt_s = pdir_r;
    drop_s     = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (trans_s[i]) begin
        if (pend_r[i] && !clr_s[i]) begin
          drop_s[i] = 1'b1;
        end else begin
          pend_nxt_s[i] = 1'b1;
          pdir_nxt_s[i] = ~stable_nxt_s[i];
        end
      end else if (clr_s[i]) begin
        pend_nxt_s[i] = 1'b0;
      end else begin
        pend_nxt_s[i] = pend_r[i];
      end
    end
    if (|drop_s) begin
      ovf_nxt_s = 1'b1;
    end else if (evt_clr) begin
      ovf_nxt_s = 1'b0;
    end else begin
      ovf_nxt_s = ovf_r;
    end
  end

  assign pop_s = (occ_r != OCC_ZERO) && evt_ready;

  // Occupancy update; a pop at full never makes room for a same-cycle push.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   occ_nxt_s = occ_r + OCC_ONE;
      2'b01:   occ_nxt_s = occ_r - OCC_ONE;
      default: occ_nxt_s = occ_r;
    endcase
  end

  // Key path state: synchronizers, debounce, toggle, pending flags and overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r  <= 4'b1111;
      sync2_r  <= 4'b1111;
      stable_r <= 4'b1111;
      for (int i = 0; i < 4; i++) cnt_r[i] <= CNT_ZERO;
      toggle_r <= 4'b0000;
      pend_r   <= 4'b0000;
      pdir_r   <= 4'b0000;
      ovf_r    <= 1'b0;
    end else begin
      sync1_r  <= key_n;
      sync2_r  <= sync1_r;
      stable_r <= stable_nxt_s;
      for (int i = 0; i < 4; i++) cnt_r[i] <= cnt_nxt_s[i];
      toggle_r <= toggle_r ^ press_s;
      pend_r   <= pend_nxt_s;
      pdir_r   <= pdir_nxt_s;
      ovf_r    <= ovf_nxt_s;
    end
  end

  // Event queue storage and pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 3'b000;
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      occ_r    <= OCC_ZERO;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_code_s;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      occ_r <= occ_nxt_s;
    end
  end

  assign key_pressed  = ~stable_r;
  assign key_toggle   = toggle_r;
  assign evt_valid    = (occ_r != OCC_ZERO);
  assign evt_code     = evt_valid ? mem_r[rd_ptr_r] : 3'b000;
  assign evt_overflow = ovf_r;

endmodule
